// File: rtl/friscv_pkg.sv
// Shared types and constants for the friscv instruction fetch slice.
// Optional misaligned-redirect trapping is selected by FRISCV_FETCH_MISALIGN_TRAP_EN.
package friscv_pkg;

  localparam int ARCH            = 32;
  localparam int ARCH_BYTES      = ARCH / 8;
  localparam int INSTR_BYTES     = ARCH_BYTES;
  localparam int IMEM_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ARCH-1:0] instr;
    logic [ARCH-1:0] pc;
  } fetch_entry_t;

  // Fetch is word granular, so the byte-offset bits of a target are dropped.
  function automatic logic [ARCH-1:0] word_align(input logic [ARCH-1:0] addr);
    return addr & ~ARCH'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/friscv_fetch_if.sv
// Instruction-memory read port: request/address out, data back one cycle later.
// Shared by the fetch unit (master) and the memory (slave); FRISCV_FETCH_MISALIGN_TRAP_EN does not affect it.
interface friscv_fetch_if;
  import friscv_pkg::*;

  logic                       req;
  logic [IMEM_ADDR_WIDTH-1:0] addr;
  logic [ARCH-1:0]            rdata;

  modport master (output req, output addr, input rdata);
  modport slave  (input req, input addr, output rdata);

endinterface

// File: rtl/friscv_fetch_skid.sv
// One-entry skid buffer catching a fetch response that arrives while decode is stalled.
// Identical in every build; FRISCV_FETCH_MISALIGN_TRAP_EN only changes the parent.
module friscv_fetch_skid
  import friscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t push_entry,
  output fetch_entry_t pop_entry,
  output logic         full
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload is qualified by 'full', so it carries no reset and
  // can map onto plain datapath flops.
  always_ff @(posedge clk) begin
    if (push) begin
      pop_entry <= push_entry;
    end
  end

endmodule

// File: rtl/friscv_fetch.sv
// Instruction fetch: sequential word fetch with redirect, decode stall and a 1-entry skid.
// Define FRISCV_FETCH_MISALIGN_TRAP_EN to add misalign_o and block fetch on misaligned redirects.
module friscv_fetch
  import friscv_pkg::*;
#(
  parameter logic [ARCH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [ARCH-1:0]  redirect_pc_i,
  friscv_fetch_if.master   imem,
  output logic [ARCH-1:0]  instr_o,
  output logic [ARCH-1:0]  pc_o,
  output logic             valid_o
`ifdef FRISCV_FETCH_MISALIGN_TRAP_EN
  ,
  output logic             misalign_o
`endif
);

  fetch_state_e    state_q;
  logic [ARCH-1:0] pc_q;
  logic [ARCH-1:0] tag_q;
  logic            inflight_q;
  logic            misalign_q;
  logic            redirect_misaligned;
  logic            fetch_en;
  logic            skid_full;
  logic            skid_push;
  logic            skid_pop;
  fetch_entry_t    skid_entry;
  fetch_entry_t    resp_entry;

`ifdef FRISCV_FETCH_MISALIGN_TRAP_EN
  assign redirect_misaligned = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign misalign_o          = misalign_q;

  // A misaligned target parks the fetcher until software redirects again.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redirect_i) begin
      misalign_q <= redirect_misaligned;
    end
  end
`else
  assign redirect_misaligned = 1'b0;
  assign misalign_q          = 1'b0;
`endif

  // New requests only when nothing is parked in the skid, so order is kept.
  assign fetch_en = !rst && (state_q == RUN || state_q == FLUSH) && !stall_i
                    && !skid_full && !misalign_q;

  assign imem.req  = fetch_en;
  assign imem.addr = pc_q[IMEM_ADDR_WIDTH-1:0];

  assign resp_entry = '{instr: imem.rdata, pc: tag_q};
  assign skid_push  = inflight_q && stall_i && !redirect_i;
  assign skid_pop   = skid_full && !stall_i && !redirect_i;

  friscv_fetch_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (skid_push),
    .pop        (skid_pop),
    .clear      (redirect_i),
    .push_entry (resp_entry),
    .pop_entry  (skid_entry),
    .full       (skid_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      valid_o    <= 1'b0;
      instr_o    <= '0;
      pc_o       <= '0;
    end else begin
      unique case (state_q)
        IDLE:    state_q <= RUN;
        RUN:     if (redirect_i) state_q <= FLUSH;
        FLUSH:   if (!redirect_i) state_q <= RUN;
        default: state_q <= IDLE;
      endcase

      // Redirect kills whatever is returning this cycle.
      inflight_q <= fetch_en && !redirect_i;
      if (fetch_en) begin
        tag_q <= pc_q;
      end

      if (redirect_i) begin
        pc_q    <= word_align(redirect_pc_i);
        valid_o <= 1'b0;
        if (redirect_misaligned) begin
          pc_o <= redirect_pc_i;
        end
      end else begin
        if (fetch_en) begin
          pc_q <= pc_q + ARCH'(INSTR_BYTES);
        end
        if (!stall_i) begin
          if (skid_full) begin
            valid_o <= 1'b1;
            instr_o <= skid_entry.instr;
            pc_o    <= skid_entry.pc;
          end else if (inflight_q) begin
            valid_o <= 1'b1;
            instr_o <= resp_entry.instr;
            pc_o    <= resp_entry.pc;
          end else begin
            valid_o <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_friscv_fetch.sv
// Scoreboard bench for friscv_fetch: directed scenarios plus randomized stall/redirect/reset.
// Compile with FRISCV_FETCH_MISALIGN_TRAP_EN to also exercise misalign_o.
module tb_friscv_fetch;
  import friscv_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

`ifdef FRISCV_FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [31:0] HI_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instr, pc, instr_hi, pc_hi;
  logic        valid, valid_hi;
`ifdef FRISCV_FETCH_MISALIGN_TRAP_EN
  logic        misalign, misalign_hi;
`endif

  int   checks = 0;
  int   failures = 0;
  int   consumed = 0;
  exp_t sb_q[$];
  logic [31:0] exp_next = '0;
  bit   mis_mode = 1'b0;

  friscv_fetch_if imem ();
  friscv_fetch_if imem_hi ();

  friscv_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem          (imem),
    .instr_o       (instr),
    .pc_o          (pc),
    .valid_o       (valid)
`ifdef FRISCV_FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign)
`endif
  );

  friscv_fetch #(.RESET_PC(HI_PC)) u_dut_hi (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (1'b0),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .imem          (imem_hi),
    .instr_o       (instr_hi),
    .pc_o          (pc_hi),
    .valid_o       (valid_hi)
`ifdef FRISCV_FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign_hi)
`endif
  );

  always #5 clk = ~clk;

  // Memory word n holds n; idle cycles return junk with bit 31 set.
  always @(posedge clk) begin
    imem.rdata    <= imem.req    ? (imem.addr >> 2)    : ($urandom() | 32'h8000_0000);
    imem_hi.rdata <= imem_hi.req ? (imem_hi.addr >> 2) : ($urandom() | 32'h8000_0000);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge, then update the reference stream from the inputs that edge sampled.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      sb_q.delete();
      exp_next = 32'h0;
      mis_mode = 1'b0;
    end else if (redirect) begin
      sb_q.delete();
      mis_mode = TRAP_EN && (redirect_pc[1:0] != 2'b00);
      exp_next = redirect_pc & ~32'h3;
    end
    if (!mis_mode) begin
      while (sb_q.size() < 8) begin
        sb_q.push_back('{pc: exp_next, instr: exp_next >> 2});
        exp_next += 32'd4;
      end
    end
  endtask

  // Monitor: compares every presented instruction to the stream head, pops on consume.
  initial begin : monitor
    bit rst_seen = 1'b1;
    bit redir_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        check("reset valid_o", 32'(valid), 32'h0);
        check("reset pc_o", pc, 32'h0);
        check("reset instr_o", instr, 32'h0);
        check("reset imem_req_o", 32'(imem.req), 32'h0);
      end else begin
        if (redir_seen) check("valid_o after redirect", 32'(valid), 32'h0);
        if (stall) check("imem_req_o while stalled", 32'(imem.req), 32'h0);
        if (mis_mode) check("imem_req_o while misaligned", 32'(imem.req), 32'h0);
`ifdef FRISCV_FETCH_MISALIGN_TRAP_EN
        check("misalign_o", 32'(misalign), 32'(mis_mode));
`endif
        if (valid) begin
          if (sb_q.size() == 0) begin
            check("valid_o with nothing expected", 32'(valid), 32'h0);
          end else begin
            check("stream pc_o", pc, sb_q[0].pc);
            check("stream instr_o", instr, sb_q[0].instr);
            if (!stall && !redirect && !rst) begin
              void'(sb_q.pop_front());
              consumed++;
            end
          end
        end
      end
      rst_seen   = rst;
      redir_seen = redirect && !rst;
    end
  end

  initial begin : stimulus
    repeat (3) step();
    rst = 1'b0;
    step(); check("first cycle out of reset valid_o", 32'(valid), 32'h0);
    step(); check("request cycle valid_o", 32'(valid), 32'h0);
    step(); check("first valid_o", 32'(valid), 32'h1);
    check("first pc_o", pc, 32'h0);
    check("first instr_o", instr, 32'h0);
    check("hi first pc_o", pc_hi, HI_PC);
    check("hi first instr_o", instr_hi, 32'h3FFF_FFFE);
    step(); check("second pc_o", pc, 32'h4);
    check("hi second pc_o", pc_hi, 32'hFFFF_FFFC);
    step(); check("third pc_o", pc, 32'h8);
    check("hi wrapped pc_o", pc_hi, 32'h0);
    check("hi wrapped instr_o", instr_hi, 32'h0);
    check("hi valid_o", 32'(valid_hi), 32'h1);
`ifdef FRISCV_FETCH_MISALIGN_TRAP_EN
    check("hi misalign_o", 32'(misalign_hi), 32'h0);
`endif

    // Stall three cycles while 0x8 is presented.
    stall = 1'b1;
    repeat (3) begin
      step();
      check("held pc_o", pc, 32'h8);
      check("held valid_o", 32'(valid), 32'h1);
    end
    stall = 1'b0;
    step(); check("skid drain pc_o", pc, 32'hC);
    step();
    step();

    redirect = 1'b1; redirect_pc = 32'h100;
    step(); redirect = 1'b0;
    check("valid_o cycle after redirect", 32'(valid), 32'h0);
    step();
    step(); check("redirect target pc_o", pc, 32'h100);
    check("redirect target instr_o", instr, 32'h40);
    check("redirect target valid_o", 32'(valid), 32'h1);

    // Fill the skid, then redirect while still stalled.
    stall = 1'b1;
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h300;
    step(); redirect = 1'b0;
    check("valid_o after stalled redirect", 32'(valid), 32'h0);
    step(); step();
    stall = 1'b0;
    step(); step();
    check("post-skid-clear pc_o", pc, 32'h300);
    check("post-skid-clear valid_o", 32'(valid), 32'h1);

    redirect = 1'b1; redirect_pc = 32'h102;
    step(); redirect = 1'b0;
    check("valid_o after 0x102 redirect", 32'(valid), 32'h0);
`ifdef FRISCV_FETCH_MISALIGN_TRAP_EN
    check("misalign_o set", 32'(misalign), 32'h1);
    check("misalign pc_o", pc, 32'h102);
    repeat (3) begin
      step();
      check("imem_req_o blocked", 32'(imem.req), 32'h0);
      check("valid_o blocked", 32'(valid), 32'h0);
    end
`else
    step(); step();
    check("low bits ignored pc_o", pc, 32'h100);
    check("low bits ignored instr_o", instr, 32'h40);
`endif
    redirect = 1'b1; redirect_pc = 32'h200;
    step(); redirect = 1'b0;
`ifdef FRISCV_FETCH_MISALIGN_TRAP_EN
    check("misalign_o cleared", 32'(misalign), 32'h0);
`endif
    step(); step();
    check("0x200 pc_o", pc, 32'h200);
    check("0x200 valid_o", 32'(valid), 32'h1);

    // Reset while the skid holds an entry.
    stall = 1'b1;
    step(); step();
    rst = 1'b1; stall = 1'b0;
    step(); rst = 1'b0;
    step(); step(); step();
    check("post mid-reset pc_o", pc, 32'h0);
    check("post mid-reset valid_o", 32'(valid), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      stall    = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < 6);
      redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | ($urandom() & 32'h1C))
                                                 : ($urandom() & 32'h0000_FFFC);
      if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    rst = 1'b0; stall = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h40;
    step(); redirect = 1'b0;
    repeat (6) step();
    check("stream live at end", 32'(valid), 32'h1);
    check("enough instructions consumed", 32'(consumed > 500), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
